// File: rtl/usart_tx_engine.sv
// -----------------------------------------------------------------------------
// usart_tx_engine
//
// USART transmit engine: a one-character holding buffer feeding a frame
// shifter.  Each frame is: start bit (0), 5..8 data bits LSB first, an
// optional parity bit, and 1 or 2 stop bits (1).  Bit timing comes from the
// shared oversampling tick `en`; every bit lasts exactly P_OVS ticks.
//
// Optional feature macro: USART_TX_PARITY_EN
//   defined   -> PARITY state and parity generation are built in.
//   undefined -> no parity logic; par_mode is ignored.
//
// Parameters:
//   P_OVS      en ticks per bit period (8 or 16)
//
// Ports:
//   clk        in   clock
//   nrst       in   asynchronous active-low reset
//   en         in   baud oversampling tick, one clk wide
//   txen       in   transmitter enable (gates new writes only)
//   csz[1:0]   in   character size: 00=5, 01=6, 10=7, 11=8 bits
//   par_mode   in   00/01 none, 10 even, 11 odd
//   stop2      in   1 selects two stop bits
//   wr_data    in   character to send
//   wr_stb     in   one-cycle write strobe
//   udre       out  holding buffer empty (reset 1)
//   txc        out  one-cycle pulse at frame end with nothing pending
//   busy       out  shifter not idle
//   txd        out  registered serial output (reset 1)
//   dbg_state  out  current FSM state encoding
//
// Write handshake: udre acts as "ready" and wr_stb as "valid".  A character
// is accepted on a clock edge where wr_stb & udre & txen are all 1; any other
// strobe is dropped without side effects.  udre then stays 0 until the
// character moves into the shifter.
// -----------------------------------------------------------------------------
module usart_tx_engine #(
    parameter int P_OVS = 16
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       en,
    input  logic       txen,
    input  logic [1:0] csz,
    input  logic [1:0] par_mode,
    input  logic       stop2,
    input  logic [7:0] wr_data,
    input  logic       wr_stb,
    output logic       udre,
    output logic       txc,
    output logic       busy,
    output logic       txd,
    output logic [2:0] dbg_state
);

    localparam int TW = $clog2(P_OVS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef USART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP1  = 3'd4,
        S_STOP2  = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      buf_q;
    logic            udre_q;
    logic [7:0]      shift_q;
    logic [TW-1:0]   tick_q;
    logic [2:0]      bit_q;
    logic [2:0]      last_bit_q;   // index of final data bit, N-1
    logic            stop2_q;
    logic            txd_q, txd_d;
    logic            txc_q, txc_d;

    logic            bit_end;
    logic            load;
    logic            frame_end;
    logic            shift_adv;
    logic            bit_inc;
    logic            wr_accept;

`ifdef USART_TX_PARITY_EN
    logic            par_en_q;
    logic            par_bit_q;
    logic [7:0]      data_mask;
    logic            par_bit_d;

    // Parity is computed once from the masked buffer at load time, so the
    // bit is ready long before the PARITY slot.
    always_comb begin
        data_mask = 8'hFF;
        case (csz)
            2'b00:   data_mask = 8'h1F;
            2'b01:   data_mask = 8'h3F;
            2'b10:   data_mask = 8'h7F;
            default: data_mask = 8'hFF;
        endcase
        par_bit_d = (^(buf_q & data_mask)) ^ par_mode[0];
    end
`else
    logic            unused_par;
    assign unused_par = ^par_mode;
`endif

    assign wr_accept = wr_stb & udre_q & txen;
    assign bit_end   = en && (tick_q == TW'(P_OVS - 1));

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        txd_d     = txd_q;
        txc_d     = 1'b0;
        load      = 1'b0;
        frame_end = 1'b0;
        shift_adv = 1'b0;
        bit_inc   = 1'b0;

        case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (!udre_q) begin
                    load = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    txd_d     = shift_q[0];
                    shift_adv = 1'b1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_q == last_bit_q) begin
`ifdef USART_TX_PARITY_EN
                        if (par_en_q) begin
                            state_d = S_PARITY;
                            txd_d   = par_bit_q;
                        end else begin
                            state_d = S_STOP1;
                            txd_d   = 1'b1;
                        end
`else
                        state_d = S_STOP1;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        // shift_q already holds the next bit in position 0
                        bit_inc   = 1'b1;
                        txd_d     = shift_q[0];
                        shift_adv = 1'b1;
                    end
                end
            end
`ifdef USART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP1;
                    txd_d   = 1'b1;
                end
            end
`endif
            S_STOP1: begin
                if (bit_end) begin
                    if (stop2_q) begin
                        state_d = S_STOP2;
                        txd_d   = 1'b1;
                    end else begin
                        frame_end = 1'b1;
                    end
                end
            end
            S_STOP2: begin
                if (bit_end) begin
                    frame_end = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                txd_d   = 1'b1;
            end
        endcase

        // A pending character chains straight into the next start bit.
        if (frame_end) begin
            if (!udre_q) begin
                load = 1'b1;
            end else begin
                state_d = S_IDLE;
                txd_d   = 1'b1;
                txc_d   = 1'b1;
            end
        end

        if (load) begin
            state_d = S_START;
            txd_d   = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= S_IDLE;
            buf_q      <= 8'h00;
            udre_q     <= 1'b1;
            shift_q    <= 8'h00;
            tick_q     <= '0;
            bit_q      <= 3'd0;
            last_bit_q <= 3'd7;
            stop2_q    <= 1'b0;
            txd_q      <= 1'b1;
            txc_q      <= 1'b0;
`ifdef USART_TX_PARITY_EN
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            txd_q   <= txd_d;
            txc_q   <= txc_d;

            // load needs udre_q=0 and a write needs udre_q=1, so they never
            // collide; a strobe on the load edge is simply dropped.
            if (load) begin
                udre_q <= 1'b1;
            end else if (wr_accept) begin
                buf_q  <= wr_data;
                udre_q <= 1'b0;
            end

            if (load) begin
                tick_q <= '0;
            end else if (state_q != S_IDLE && en) begin
                tick_q <= bit_end ? '0 : tick_q + 1'b1;
            end

            if (load) begin
                bit_q <= 3'd0;
            end else if (bit_inc) begin
                bit_q <= bit_q + 3'd1;
            end

            if (load) begin
                shift_q <= buf_q;
            end else if (shift_adv) begin
                shift_q <= shift_q >> 1;
            end

            // Frame format is frozen for the whole frame at load.
            if (load) begin
                last_bit_q <= {1'b0, csz} + 3'd4;
                stop2_q    <= stop2;
`ifdef USART_TX_PARITY_EN
                par_en_q   <= par_mode[1];
                par_bit_q  <= par_bit_d;
`endif
            end
        end
    end

    assign udre      = udre_q;
    assign txc       = txc_q;
    assign busy      = (state_q != S_IDLE);
    assign txd       = txd_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_usart_tx_engine.sv
// -----------------------------------------------------------------------------
// tb_usart_tx_engine
//
// Directed bench for usart_tx_engine (P_OVS=16).  Inputs are driven and
// outputs sampled on the falling clock edge; the DUT acts on the rising edge.
// Frames are described as bit vectors {stops, parity, data, start} so bit i
// is the i-th bit on the line; txd is checked on every clock of every bit.
// -----------------------------------------------------------------------------
module tb_usart_tx_engine;

    logic       clk;
    logic       nrst;
    logic       en;
    logic       txen;
    logic [1:0] csz;
    logic [1:0] par_mode;
    logic       stop2;
    logic [7:0] wr_data;
    logic       wr_stb;
    logic       udre;
    logic       txc;
    logic       busy;
    logic       txd;
    logic [2:0] dbg_state;

    int n_vec;
    int n_err;
    int ph;
    bit en_div4;

    // writes scheduled at a cycle offset inside run_bits
    int         sched_cyc [2];
    logic [7:0] sched_val [2];

    usart_tx_engine #(.P_OVS(16)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .en        (en),
        .txen      (txen),
        .csz       (csz),
        .par_mode  (par_mode),
        .stop2     (stop2),
        .wr_data   (wr_data),
        .wr_stb    (wr_stb),
        .udre      (udre),
        .txc       (txc),
        .busy      (busy),
        .txd       (txd),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and set en for the following rising edge.
    task automatic step();
        @(negedge clk);
        ph++;
        en = en_div4 ? (ph % 4 == 0) : 1'b1;
    endtask

    task automatic write_char(input logic [7:0] v);
        wr_data = v;
        wr_stb  = 1'b1;
        step();
        wr_stb  = 1'b0;
    endtask

    // Check nbits line bits of cpb clocks each, starting at the current
    // falling edge, applying any scheduled writes along the way.
    task automatic run_bits(input string tag, input logic [23:0] bits,
                            input int nbits, input int cpb);
        for (int i = 0; i < nbits; i++) begin
            for (int c = 0; c < cpb; c++) begin
                chk($sformatf("%s_txd_b%0d_c%0d", tag, i, c), txd, bits[i]);
                chk($sformatf("%s_txc_b%0d_c%0d", tag, i, c), txc, 1'b0);
                chk($sformatf("%s_busy_b%0d_c%0d", tag, i, c), busy, 1'b1);
                for (int s = 0; s < 2; s++) begin
                    if (sched_cyc[s] == i * cpb + c) begin
                        wr_data = sched_val[s];
                        wr_stb  = 1'b1;
                    end
                end
                step();
                wr_stb = 1'b0;
            end
        end
    endtask

    // Write one character into an idle DUT and check the whole frame.
    task automatic send_frame(input string tag, input logic [7:0] v,
                              input logic [23:0] bits, input int nbits, input int cpb);
        write_char(v);
        chk({tag, "_udre_after_wr"}, udre, 1'b0);
        chk({tag, "_txd_before_load"}, txd, 1'b1);
        step();
        chk({tag, "_udre_at_load"}, udre, 1'b1);
        chk({tag, "_state_start"}, dbg_state, 3'd1);
        run_bits(tag, bits, nbits, cpb);
        chk({tag, "_txc_pulse"}, txc, 1'b1);
        chk({tag, "_busy_end"}, busy, 1'b0);
        chk({tag, "_txd_end"}, txd, 1'b1);
        step();
        chk({tag, "_txc_clear"}, txc, 1'b0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        ph = 0;
        en_div4 = 1'b0;
        en = 1'b1;
        nrst = 1'b0;
        txen = 1'b1;
        csz = 2'b11;
        par_mode = 2'b00;
        stop2 = 1'b0;
        wr_data = 8'h00;
        wr_stb = 1'b0;
        sched_cyc[0] = -1;
        sched_cyc[1] = -1;
        sched_val[0] = 8'h00;
        sched_val[1] = 8'h00;

        // reset values
        repeat (3) step();
        chk("rst_udre", udre, 1'b1);
        chk("rst_txc", txc, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_txd", txd, 1'b1);
        chk("rst_state", dbg_state, 3'd0);
        nrst = 1'b1;
        repeat (2) step();

        // write with txen=0 is dropped
        txen = 1'b0;
        write_char(8'h3C);
        chk("txen0_udre", udre, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("txen0_txd", txd, 1'b1);
            chk("txen0_busy", busy, 1'b0);
        end
        txen = 1'b1;

        // 8N1, 0x55
        send_frame("8n1", 8'h55, {1'b1, 8'h55, 1'b0}, 10, 16);
        repeat (5) step();

        // 6 data bits, 0xC5: upper bits ignored; txen dropped mid-frame
        csz = 2'b01;
        write_char(8'hC5);
        chk("6n1_udre_after_wr", udre, 1'b0);
        step();
        txen = 1'b0;
        run_bits("6n1", {1'b1, 6'h05, 1'b0}, 8, 16);
        chk("6n1_txc_pulse", txc, 1'b1);
        step();
        chk("6n1_txc_clear", txc, 1'b0);
        txen = 1'b1;
        csz = 2'b11;
        repeat (5) step();

`ifdef USART_TX_PARITY_EN
        // even and odd parity on 0xA3 (four ones)
        par_mode = 2'b10;
        send_frame("8e1", 8'hA3, {1'b1, 1'b0, 8'hA3, 1'b0}, 11, 16);
        repeat (5) step();
        par_mode = 2'b11;
        send_frame("8o1", 8'hA3, {1'b1, 1'b1, 8'hA3, 1'b0}, 11, 16);
        repeat (5) step();
        par_mode = 2'b00;
`endif

        // 5 data bits, two stops, en every 4th clock: 64 clocks per bit
        csz = 2'b00;
        stop2 = 1'b1;
        en_div4 = 1'b1;
        while (ph % 4 != 3) step();
        send_frame("5n2", 8'hFF, {2'b11, 5'h1F, 1'b0}, 8, 64);
        en_div4 = 1'b0;
        csz = 2'b11;
        stop2 = 1'b0;
        repeat (5) step();

        // back-to-back: 0x80 written during START chains with no gap,
        // 0xFF written while udre=0 is dropped
        write_char(8'h01);
        step();
        sched_cyc[0] = 3;
        sched_val[0] = 8'h80;
        sched_cyc[1] = 40;
        sched_val[1] = 8'hFF;
        run_bits("b2b_1", {1'b1, 8'h01, 1'b0}, 10, 16);
        sched_cyc[0] = -1;
        sched_cyc[1] = -1;
        run_bits("b2b_2", {1'b1, 8'h80, 1'b0}, 10, 16);
        chk("b2b_txc_pulse", txc, 1'b1);
        step();
        chk("b2b_txc_clear", txc, 1'b0);
        chk("b2b_udre", udre, 1'b1);
        for (int i = 0; i < 40; i++) begin
            chk("b2b_idle_txd", txd, 1'b1);
            chk("b2b_idle_busy", busy, 1'b0);
            chk("b2b_idle_txc", txc, 1'b0);
            step();
        end

        // reset mid-frame (during data bit 3) with a character buffered
        write_char(8'h55);
        step();
        sched_cyc[0] = 2;
        sched_val[0] = 8'hAA;
        run_bits("rstmid", {8'h55, 1'b0}, 4, 16);
        sched_cyc[0] = -1;
        repeat (5) step();
        chk("rstmid_pre_udre", udre, 1'b0);
        nrst = 1'b0;
        #1;
        chk("rstmid_txd", txd, 1'b1);
        chk("rstmid_udre", udre, 1'b1);
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_txc", txc, 1'b0);
        chk("rstmid_state", dbg_state, 3'd0);
        step();
        nrst = 1'b1;
        for (int i = 0; i < 200; i++) begin
            step();
            chk("rstmid_after_txd", txd, 1'b1);
            chk("rstmid_after_busy", busy, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
